// File: rtl/adc128s022_scan.sv
// ADC128S022 round-robin SPI scanner: one 16-SCLK frame per conversion.
// Define ADC_AVG_EN to report 4-sample per-channel averages instead of raw data.
module adc128s022_scan #(
   parameter int CLK_DIV  = 8,
   parameter int CS_SETUP = 8
) (
   input  logic        CLK50MHZ,
   input  logic        reset,
   input  logic        en,
   input  logic [7:0]  chan_mask,
   output logic        ADC_CS_N,
   output logic        ADC_SCLK,
   output logic        ADC_SADDR,
   input  logic        ADC_SDAT,
   output logic        sample_valid,
   output logic [2:0]  sample_chan,
   output logic [11:0] sample_data,
   output logic        busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;

   localparam int GAP = 2 * CLK_DIV;
   localparam int CW  = $clog2(GAP + CS_SETUP + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_cnt;
   logic [2:0]    addr_q;
   logic [2:0]    rx_chan;
   logic          report;
   logic [11:0]   shreg;
   logic          pend;
   logic [2:0]    base;
   logic [2:0]    idx;
   logic [2:0]    nxt;
   logic [15:0]   ctrl;
   logic          go;

`ifdef ADC_AVG_EN
   logic [13:0] acc [8];
   logic [1:0]  avg_cnt [8];
   logic [13:0] avg_sum;

   // Running sum for the channel whose result is being retired
   always_comb begin
      avg_sum = acc[rx_chan] + {2'b00, shreg};
   end
`endif

   assign busy = ~ADC_CS_N;
   assign ctrl = {2'b00, addr_q, 11'd0};
   assign go   = en && (chan_mask != 8'd0);

   // Next address: lowest enabled channel above the current one, wrapping
   always_comb begin
      base = (state == SETUP) ? 3'd0 : addr_q;
      nxt  = base;
      idx  = 3'd0;
      for (int k = 8; k >= 1; k--) begin
         idx = base + 3'(k);
         if (chan_mask[idx]) nxt = idx;
      end
   end

   // Frame sequencer, SPI shifter and result reporting
   always_ff @(posedge CLK50MHZ) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_cnt      <= '0;
         addr_q       <= '0;
         rx_chan      <= '0;
         report       <= 1'b0;
         shreg        <= '0;
         pend         <= 1'b0;
         ADC_CS_N     <= 1'b1;
         ADC_SCLK     <= 1'b1;
         ADC_SADDR    <= 1'b0;
         sample_valid <= 1'b0;
         sample_chan  <= '0;
         sample_data  <= '0;
`ifdef ADC_AVG_EN
         for (int i = 0; i < 8; i++) begin
            acc[i]     <= '0;
            avg_cnt[i] <= '0;
         end
`endif
      end else begin
         sample_valid <= 1'b0;
         pend         <= 1'b0;
         if (pend && report) begin
`ifdef ADC_AVG_EN
            if (avg_cnt[rx_chan] == 2'd3) begin
               sample_valid     <= 1'b1;
               sample_chan      <= rx_chan;
               sample_data      <= avg_sum[13:2];
               acc[rx_chan]     <= '0;
               avg_cnt[rx_chan] <= '0;
            end else begin
               acc[rx_chan]     <= avg_sum;
               avg_cnt[rx_chan] <= avg_cnt[rx_chan] + 2'd1;
            end
`else
            sample_valid <= 1'b1;
            sample_chan  <= rx_chan;
            sample_data  <= shreg;
`endif
         end
         case (state)
            IDLE: begin
               ADC_CS_N  <= 1'b1;
               ADC_SCLK  <= 1'b1;
               ADC_SADDR <= 1'b0;
`ifdef ADC_AVG_EN
               for (int i = 0; i < 8; i++) begin
                  acc[i]     <= '0;
                  avg_cnt[i] <= '0;
               end
`endif
               if (cnt != GAP_LAST) begin
                  cnt <= cnt + 1'b1;
               end else if (go) begin
                  ADC_CS_N <= 1'b0;
                  state    <= SETUP;
                  cnt      <= '0;
               end
            end
            SETUP: begin
               if (cnt == SET_LAST) begin
                  state     <= SHIFT;
                  cnt       <= '0;
                  bit_cnt   <= '0;
                  ADC_SCLK  <= 1'b0;
                  ADC_SADDR <= 1'b0;
                  addr_q    <= nxt;
                  rx_chan   <= 3'd0;
                  report    <= chan_mask[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt != DIV_LAST) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  cnt <= '0;
                  if (!ADC_SCLK) begin
                     ADC_SCLK <= 1'b1;
                     shreg    <= {shreg[10:0], ADC_SDAT};
                     if (bit_cnt == 4'd15) pend <= 1'b1;
                  end else if (bit_cnt != 4'd15) begin
                     ADC_SCLK  <= 1'b0;
                     bit_cnt   <= bit_cnt + 4'd1;
                     ADC_SADDR <= ctrl[4'd14 - bit_cnt];
                  end else if (go) begin
                     ADC_SCLK  <= 1'b0;
                     bit_cnt   <= '0;
                     ADC_SADDR <= 1'b0;
                     addr_q    <= nxt;
                     rx_chan   <= addr_q;
                     report    <= 1'b1;
                  end else begin
                     state     <= IDLE;
                     ADC_CS_N  <= 1'b1;
                     ADC_SADDR <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc128s022_scan.sv
// Scoreboard bench for adc128s022_scan with a behavioural ADC128S022 model.
// Define ADC_AVG_EN to also exercise the averaging build.
module tb_adc128s022_scan;

   logic        CLK50MHZ = 1'b0;
   logic        reset;
   logic        en;
   logic [7:0]  chan_mask;
   logic        ADC_CS_N;
   logic        ADC_SCLK;
   logic        ADC_SADDR;
   logic        ADC_SDAT;
   logic        sample_valid;
   logic [2:0]  sample_chan;
   logic [11:0] sample_data;
   logic        busy;

   always #10 CLK50MHZ = ~CLK50MHZ;

   adc128s022_scan #(.CLK_DIV(8), .CS_SETUP(8)) dut (
      .CLK50MHZ    (CLK50MHZ),
      .reset       (reset),
      .en          (en),
      .chan_mask   (chan_mask),
      .ADC_CS_N    (ADC_CS_N),
      .ADC_SCLK    (ADC_SCLK),
      .ADC_SADDR   (ADC_SADDR),
      .ADC_SDAT    (ADC_SDAT),
      .sample_valid(sample_valid),
      .sample_chan (sample_chan),
      .sample_data (sample_data),
      .busy        (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [2:0]  ch;
      logic [11:0] d;
   } exp_t;
   exp_t sb_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out", nm);
   endtask

   // ADC model
   int          mode = 0;
   int          rise_cnt = 0;
   int          sclk_rises = 0;
   int          avg_idx = 0;
   logic [2:0]  cur_ch = 3'd0;
   logic [2:0]  din_addr = 3'd0;
   logic [2:0]  addr_log[$];
   logic [15:0] word;
   logic [11:0] avg_tab [4] = '{12'd100, 12'd200, 12'd300, 12'd404};

   function automatic logic [11:0] adc_val(input logic [2:0] ch);
      case (mode)
         0:       return 12'hA5C;
         1:       return 12'h100 + {9'd0, ch};
         default: return (ch == 3'd3) ? avg_tab[avg_idx % 4] : 12'd0;
      endcase
   endfunction

   initial ADC_SDAT = 1'b0;

   always @(negedge ADC_CS_N) begin
      rise_cnt = 0;
      cur_ch   = 3'd0;
      ADC_SDAT = 1'b0;
   end

   always @(posedge ADC_CS_N) rise_cnt = 0;

   always @(posedge ADC_SCLK) begin
      if (!ADC_CS_N) begin
         sclk_rises++;
         if (rise_cnt >= 2 && rise_cnt <= 4) din_addr[4-rise_cnt] = ADC_SADDR;
         rise_cnt++;
         if (rise_cnt == 16) begin
            rise_cnt = 0;
            addr_log.push_back(din_addr);
            if (cur_ch == 3'd3) avg_idx++;
            cur_ch = din_addr;
         end
      end
   end

   always @(negedge ADC_SCLK) begin
      if (!ADC_CS_N) begin
         word     = {4'd0, adc_val(cur_ch)};
         ADC_SDAT = word[15-rise_cnt];
      end
   end

   // Monitor: pops expected results on every strobe
   logic sclk_d = 1'b1;
   int   cyc_rise = 0;
   exp_t e;

   always @(negedge CLK50MHZ) begin
      if (ADC_SCLK && !sclk_d) cyc_rise = 0;
      else cyc_rise++;
      sclk_d = ADC_SCLK;
      if (sample_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: actual chan=%0d data=0x%h required none",
                     sample_chan, sample_data);
         end else begin
            e = sb_q.pop_front();
            chk("strobe_chan", 32'(sample_chan), 32'(e.ch));
            chk("strobe_data", 32'(sample_data), 32'(e.d));
            chk("strobe_latency", cyc_rise, 1);
         end
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK50MHZ);
   endtask

   task automatic wait_cs(input logic lvl, input string nm);
      for (int i = 0; i < 3000; i++) begin
         if (ADC_CS_N === lvl) return;
         @(negedge CLK50MHZ);
      end
      timeout(nm);
   endtask

   task automatic wait_empty(input string nm);
      for (int i = 0; i < 4000; i++) begin
         if (sb_q.size() == 0) return;
         @(negedge CLK50MHZ);
      end
      timeout(nm);
   endtask

   task automatic wait_rise(input int n, input string nm);
      for (int i = 0; i < 600; i++) begin
         if (!ADC_CS_N && rise_cnt == n) return;
         @(negedge CLK50MHZ);
      end
      timeout(nm);
   endtask

   task automatic wait_log(input int n, input string nm);
      for (int i = 0; i < 1000; i++) begin
         if (addr_log.size() >= n) return;
         @(negedge CLK50MHZ);
      end
      timeout(nm);
   endtask

   task automatic push(input logic [2:0] ch, input logic [11:0] d);
      sb_q.push_back({ch, d});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int cnt;
   int rises0;
   int low_cnt;
   logic [2:0] exp_addr [6] = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5, 3'd7};

   initial begin
      reset     = 1'b1;
      en        = 1'b0;
      chan_mask = 8'h00;
      cyc(5);
      chk("rst_cs_n", 32'(ADC_CS_N), 1);
      chk("rst_sclk", 32'(ADC_SCLK), 1);
      chk("rst_saddr", 32'(ADC_SADDR), 0);
      chk("rst_valid", 32'(sample_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", 32'(sample_data), 0);
      chk("rst_chan", 32'(sample_chan), 0);
      reset = 1'b0;
      cyc(2);

      // Test 1: constant 0xA5C, channel 0 only
      mode       = 0;
      chan_mask  = 8'h01;
      sclk_rises = 0;
      push(3'd0, 12'hA5C);
      push(3'd0, 12'hA5C);
      en = 1'b1;
      wait_cs(1'b0, "t1_cs_fall");
      cnt = 0;
      for (int i = 0; i < 100 && ADC_SCLK; i++) begin
         @(negedge CLK50MHZ);
         cnt++;
      end
      chk("t1_cs_setup", cnt, 8);
      chk("t1_busy", 32'(busy), 1);
      cnt = 0;
      for (int i = 0; i < 100 && !ADC_SCLK; i++) begin
         @(negedge CLK50MHZ);
         cnt++;
      end
      chk("t1_sclk_low", cnt, 8);
      cnt = 0;
      for (int i = 0; i < 100 && ADC_SCLK; i++) begin
         @(negedge CLK50MHZ);
         cnt++;
      end
      chk("t1_sclk_high", cnt, 8);
      wait_empty("t1_results");
      en = 1'b0;
      wait_cs(1'b1, "t1_cs_rise");
      chk("t1_sclk_rises", sclk_rises, 32);
      chk("t1_busy_off", 32'(busy), 0);

      // Test 2: mask 1010_0100, per-channel data
      mode      = 1;
      chan_mask = 8'b1010_0100;
      addr_log.delete();
      push(3'd2, 12'h102);
      push(3'd5, 12'h105);
      push(3'd7, 12'h107);
      push(3'd2, 12'h102);
      push(3'd5, 12'h105);
      en  = 1'b1;
      cnt = 0;
      for (int i = 0; i < 200 && ADC_CS_N; i++) begin
         @(negedge CLK50MHZ);
         cnt++;
      end
      chk("t2_cs_gap_ok", 32'(cnt >= 16), 1);
      wait_empty("t2_results");
      en = 1'b0;
      wait_cs(1'b1, "t2_cs_rise");
      chk("t2_frames", addr_log.size(), 6);
      for (int i = 0; i < 6 && i < addr_log.size(); i++)
         chk($sformatf("t2_saddr_%0d", i), 32'(addr_log[i]), 32'(exp_addr[i]));

      // Test 3: en dropped mid-frame
      chan_mask = 8'h01;
      push(3'd0, 12'h100);
      en = 1'b1;
      wait_cs(1'b0, "t3_cs_fall");
      wait_rise(6, "t3_bit6");
      en = 1'b0;
      wait_cs(1'b1, "t3_cs_rise");
      chk("t3_strobed", sb_q.size(), 0);
      chk("t3_busy", 32'(busy), 0);
      rises0  = sclk_rises;
      low_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK50MHZ);
         if (!ADC_CS_N || !ADC_SCLK) low_cnt++;
      end
      chk("t3_quiet", low_cnt, 0);
      chk("t3_no_rises", sclk_rises - rises0, 0);

      // Test 4: reset mid-frame
      en = 1'b1;
      wait_cs(1'b0, "t4_cs_fall");
      wait_rise(9, "t4_bit9");
      reset = 1'b1;
      @(negedge CLK50MHZ);
      chk("t4_cs_n", 32'(ADC_CS_N), 1);
      chk("t4_sclk", 32'(ADC_SCLK), 1);
      chk("t4_busy", 32'(busy), 0);
      cyc(3);
      chk("t4_data_clr", 32'(sample_data), 0);
      chan_mask = 8'h05;
      push(3'd0, 12'h100);
      push(3'd2, 12'h102);
      reset = 1'b0;
      wait_empty("t4_results");
      en = 1'b0;
      wait_cs(1'b1, "t4_cs_rise");

      // Test 5: empty mask, then mid-frame mask change
      chan_mask = 8'h00;
      en        = 1'b1;
      low_cnt   = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK50MHZ);
         if (!ADC_CS_N || busy) low_cnt++;
      end
      chk("t5_idle", low_cnt, 0);
      addr_log.delete();
      push(3'd0, 12'h100);
      push(3'd0, 12'h100);
      chan_mask = 8'h01;
      wait_cs(1'b0, "t5_cs_fall");
      wait_rise(8, "t5_bit8");
      chan_mask = 8'h81;
      wait_log(1, "t5_frame1");
      wait_rise(3, "t5_frame2");
      en = 1'b0;
      wait_cs(1'b1, "t5_cs_rise");
      chk("t5_frames", addr_log.size(), 2);
      if (addr_log.size() >= 2) begin
         chk("t5_addr_old", 32'(addr_log[0]), 0);
         chk("t5_addr_new", 32'(addr_log[1]), 7);
      end
      chk("t5_results", sb_q.size(), 0);

`ifdef ADC_AVG_EN
      // Test 6: four-sample average on channel 3
      mode      = 2;
      avg_idx   = 0;
      chan_mask = 8'h08;
      push(3'd3, 12'd251);
      en = 1'b1;
      wait_empty("t6_results");
      en = 1'b0;
      wait_cs(1'b1, "t6_cs_rise");
      chk("t6_frames_seen", avg_idx, 4);
`endif

      cyc(20);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
